cacheline_arbiter: RTL and testbench
====================================

# cacheline_arbiter

Two-master, one-slave arbiter that shares the single 256-bit physical memory port between the instruction cache and the data cache. It sits between both caches' pmem-side interfaces and the cacheline adaptor, below the pipeline. Requests are granted with data-side priority plus a starvation bound for the instruction side. Grant state, address and write data are latched until the memory responds.

## Interface
Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cacheline width.
- STARVE_MAX, 2, maximum consecutive D grants while I waits before I is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp.
- i_pmem_address  in  ADDR_W  I-cache line address (bits [4:0] zero).
- i_pmem_rdata  out  LINE_W  line returned to the I-cache.
- i_pmem_resp  out  1  I-side completion pulse.
- d_pmem_read  in  1  D-cache line read request.
- d_pmem_write  in  1  D-cache line writeback request.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache writeback line.
- d_pmem_rdata  out  LINE_W  line returned to the D-cache.
- d_pmem_resp  out  1  D-side completion pulse.
- pmem_read  out  1  read to the adaptor.
- pmem_write  out  1  write to the adaptor.
- pmem_address  out  ADDR_W  latched address.
- pmem_wdata  out  LINE_W  latched write line.
- pmem_rdata  in  LINE_W  line from the adaptor.
- pmem_resp  in  1  adaptor completion, one cycle.

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY.
- **IDLE, grant decision:**
  - Only D requesting: go to D_BUSY.
  - Only I requesting: go to I_BUSY.
  - Both requesting: grant D, unless d_streak == STARVE_MAX, in which case grant I.
- **On grant:** latch the winner's address, op (read/write) and wdata into pmem_address, pmem_read/pmem_write and pmem_wdata. These are registered and held constant through the BUSY state.
- **d_streak** (saturating, width clog2(STARVE_MAX+1)):
  - Increments on a D grant when i_pmem_read is high in the same cycle.
  - Clears on any I grant.
  - Holds otherwise.
- **BUSY:**
  - pmem_resp routes combinationally to the owner's *_resp in the same cycle.
  - pmem_rdata drives both *_rdata unconditionally. The non-owner's resp stays 0.
  - In that same cycle, clear pmem_read/pmem_write and return to IDLE.
- **d_pmem_read and d_pmem_write both high:** illegal. Write wins; an assertion fires in simulation.
- **Requester drops its request before resp:** ignored. The transaction completes, and the resp is still forwarded.
- **pmem_resp in IDLE:** ignored, not forwarded.
- **Reset (any state, asynchronous):**
  - State goes to IDLE, d_streak to 0.
  - pmem_read, pmem_write, pmem_address and pmem_wdata go to 0.
  - i_pmem_resp and d_pmem_resp are 0.
  - Any in-flight transaction is abandoned; the adaptor sees the request drop.

## Timing
- Request visible in IDLE at edge N: pmem_read/write asserted after edge N (cycle N+1). Arbitration overhead is 1 cycle.
- pmem_resp in cycle M: *_resp in cycle M (0 added latency). The pmem request deasserts at edge M+1.
- Back-to-back: after a resp at M, IDLE samples requests in cycle M+1, and the next pmem request is asserted in cycle M+2. There is a minimum 1-cycle gap between transactions.
- Requests must be stable from assertion to resp (cache contract). The arbiter samples them only in IDLE.

## Structure
- Add arb_state_t {IDLE, I_BUSY, D_BUSY} to the shared cpuIO package, alongside the other control enums.
- Take LINE_W/ADDR_W defaults from rv32i_types constants.
- Implement as a single module: one always_ff for state, latches and d_streak, and one always_comb for next-state and resp routing. No sub-module.

## Test plan
- **Lone I read:** i_pmem_read=1, addr 0x0000_0060, pmem_resp after 4 cycles with rdata=0xA5..A5.
  - pmem_read high 1 cycle after request, pmem_address=0x60.
  - i_pmem_resp pulses in the same cycle as pmem_resp with i_pmem_rdata=0xA5..A5.
  - d_pmem_resp stays 0.
- **Simultaneous requests:** I read 0x100 and D write 0x200 (wdata=0x1234...) asserted together.
  - D served first: pmem_write=1, pmem_wdata=0x1234...
  - After d_pmem_resp, I is served at 0x100 two cycles later.
- **Starvation:** I held at 0x40 while D issues 3 back-to-back reads.
  - Grants are D, D, then I (STARVE_MAX=2); the third D waits until after the I resp.
  - d_streak reads 0 after the I grant.
- **Reset mid-transaction:** assert rst=0 two cycles into D_BUSY.
  - pmem_read/pmem_write/pmem_address/pmem_wdata=0 immediately, without waiting for an edge.
  - After release, the state is IDLE and the stale pmem_resp is not forwarded.
- **Spurious resp:** pmem_resp=1 in IDLE gives no *_resp and no state change.
- **Illegal D read+write:** both asserted; the write is issued and the assertion fires.

Source files
------------

// File: rtl/cacheline_arbiter_pkg.sv
// cacheline_arbiter_pkg
//   Shared control types and width defaults for the cache-to-memory path.
//   - RV32I_ADDR_W / RV32I_LINE_W : default physical address and cacheline widths.
//   - arb_state_t                 : owner state of the pmem arbiter.
package cacheline_arbiter_pkg;

    localparam int unsigned RV32I_ADDR_W = 32;
    localparam int unsigned RV32I_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
//   Shares one physical memory port between the I-cache and the D-cache.
//   D-side requests win ties, except that after STARVE_MAX consecutive D grants
//   taken while I was waiting, I is granted. The winner's address, op and write
//   line are registered on grant and held until the adaptor responds.
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   i_pmem_read/address            I-cache line read request
//   i_pmem_rdata/resp              line and completion pulse back to the I-cache
//   d_pmem_read/write/address/wdata  D-cache line read or writeback request
//   d_pmem_rdata/resp              line and completion pulse back to the D-cache
//   pmem_read/write/address/wdata  registered request to the cacheline adaptor
//   pmem_rdata/resp                line and one-cycle completion from the adaptor
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = RV32I_ADDR_W,
    parameter int unsigned LINE_W     = RV32I_LINE_W,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned StreakW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_MAX);

    arb_state_t         state_q, state_d;
    logic [StreakW-1:0] d_streak_q;
    logic               d_req;
    logic               grant_i, grant_d;
    logic               resp_done;

    assign d_req = d_pmem_read | d_pmem_write;

    // Returned data goes to both caches; only the owner's resp qualifies it.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_comb begin
        state_d     = state_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        resp_done   = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                // D wins ties until it has taken StreakMax grants past a waiting I.
                if (d_req && (!i_pmem_read || d_streak_q != StreakMax)) begin
                    grant_d = 1'b1;
                    state_d = D_BUSY;
                end else if (i_pmem_read) begin
                    grant_i = 1'b1;
                    state_d = I_BUSY;
                end
            end
            I_BUSY: begin
                i_pmem_resp = pmem_resp;
                resp_done   = pmem_resp;
                if (pmem_resp) state_d = IDLE;
            end
            D_BUSY: begin
                d_pmem_resp = pmem_resp;
                resp_done   = pmem_resp;
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            d_streak_q   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                // A read+write collision is illegal; the writeback is issued.
                pmem_read    <= ~d_pmem_write;
                pmem_write   <= d_pmem_write;
                pmem_address <= d_pmem_address;
                pmem_wdata   <= d_pmem_wdata;
                if (i_pmem_read && d_streak_q != StreakMax) begin
                    d_streak_q <= d_streak_q + StreakW'(1);
                end
            end else if (grant_i) begin
                pmem_read    <= 1'b1;
                pmem_write   <= 1'b0;
                pmem_address <= i_pmem_address;
                pmem_wdata   <= '0;
                d_streak_q   <= '0;
            end else if (resp_done) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
            end
        end
    end

    // The D-cache must never ask for a read and a writeback at the same time.
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(d_pmem_read && d_pmem_write))
        else $warning("cacheline_arbiter: d_pmem_read and d_pmem_write both set");

endmodule

// File: tb/tb_cacheline_arbiter.sv
module tb_cacheline_arbiter;
    import cacheline_arbiter_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam logic [1:0]  OWN_I  = 2'b10;
    localparam logic [1:0]  OWN_D  = 2'b01;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_pmem_read = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0;
    logic              d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    always #5 clk = ~clk;

    cacheline_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    typedef struct {
        logic [1:0]        owner;
        logic [LINE_W-1:0] rdata;
    } resp_t;

    typedef struct {
        string             name;
        logic              i_rd;
        logic [ADDR_W-1:0] i_addr;
        logic              d_rd;
        logic              d_wr;
        logic [ADDR_W-1:0] d_addr;
        logic [LINE_W-1:0] d_wdata;
        int                lat;
        logic              drop;
        logic [LINE_W-1:0] rdata;
        logic              exp_rd;
        logic              exp_wr;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wdata;
        logic [1:0]        owner;
    } vec_t;

    resp_t sb[$];
    vec_t  vecs[6];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    task automatic push_resp(input logic [1:0] owner, input logic [LINE_W-1:0] rdata);
        resp_t e;
        e.owner = owner;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Every resp pulse seen by the caches must match the oldest expected completion.
    always @(negedge clk) begin
        resp_t e;
        if (rst && (i_pmem_resp || d_pmem_resp)) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
            end else begin
                e = sb.pop_front();
                check("resp_owner", LINE_W'({i_pmem_resp, d_pmem_resp}), LINE_W'(e.owner));
                check("resp_rdata", (e.owner == OWN_I) ? i_pmem_rdata : d_pmem_rdata, e.rdata);
            end
        end
    end

    initial begin
        vec_t              v;
        logic [ADDR_W-1:0] d_addrs[3];
        int                di;
        int                streak_m;
        logic              i_pend;
        logic              d_pend;
        logic              exp_d;
        logic [LINE_W-1:0] rd;

        vecs[0] = '{"lone_i_read", 1'b1, 32'h60, 1'b0, 1'b0, 32'h0, '0, 4, 1'b0,
                    {32{8'hA5}}, 1'b1, 1'b0, 32'h60, '0, OWN_I};
        vecs[1] = '{"lone_d_read", 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, {8{32'hDEADBEEF}}, 2, 1'b0,
                    {32{8'h5A}}, 1'b1, 1'b0, 32'h80, {8{32'hDEADBEEF}}, OWN_D};
        vecs[2] = '{"lone_d_write", 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, {16{16'h1234}}, 3, 1'b0,
                    '0, 1'b0, 1'b1, 32'h200, {16{16'h1234}}, OWN_D};
        vecs[3] = '{"d_read_dropped", 1'b0, 32'h0, 1'b1, 1'b0, 32'hC0, '0, 3, 1'b1,
                    {8{32'h0BADF00D}}, 1'b1, 1'b0, 32'hC0, '0, OWN_D};
        vecs[4] = '{"illegal_rw", 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, {8{32'hCAFEF00D}}, 1, 1'b0,
                    {8{32'h11112222}}, 1'b0, 1'b1, 32'h300, {8{32'hCAFEF00D}}, OWN_D};
        vecs[5] = '{"i_read_dropped", 1'b1, 32'h7E0, 1'b0, 1'b0, 32'h0, '0, 0, 1'b1,
                    {8{32'h76543210}}, 1'b1, 1'b0, 32'h7E0, '0, OWN_I};

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("rst_pmem_read", LINE_W'(pmem_read), '0);
        check("rst_pmem_write", LINE_W'(pmem_write), '0);
        check("rst_pmem_address", LINE_W'(pmem_address), '0);
        check("rst_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
        check("rst_state", LINE_W'(dut.state_q), LINE_W'(IDLE));
        check("rst_streak", LINE_W'(dut.d_streak_q), '0);
        step();
        step();
        rst = 1'b1;
        step();

        // Single transactions from IDLE
        foreach (vecs[k]) begin
            v = vecs[k];
            i_pmem_read    = v.i_rd;
            i_pmem_address = v.i_addr;
            d_pmem_read    = v.d_rd;
            d_pmem_write   = v.d_wr;
            d_pmem_address = v.d_addr;
            d_pmem_wdata   = v.d_wdata;
            step();
            check({v.name, "_read"}, LINE_W'(pmem_read), LINE_W'(v.exp_rd));
            check({v.name, "_write"}, LINE_W'(pmem_write), LINE_W'(v.exp_wr));
            check({v.name, "_addr"}, LINE_W'(pmem_address), LINE_W'(v.exp_addr));
            check({v.name, "_wdata"}, pmem_wdata, v.exp_wdata);
            if (v.drop) clear_reqs();
            repeat (v.lat) step();
            check({v.name, "_held_addr"}, LINE_W'(pmem_address), LINE_W'(v.exp_addr));
            pmem_resp  = 1'b1;
            pmem_rdata = v.rdata;
            push_resp(v.owner, v.rdata);
            step();
            pmem_resp = 1'b0;
            clear_reqs();
            check({v.name, "_resp_seen"}, LINE_W'(sb.size()), '0);
            check({v.name, "_req_cleared"}, LINE_W'({pmem_read, pmem_write}), '0);
            check({v.name, "_idle"}, LINE_W'(dut.state_q), LINE_W'(IDLE));
        end

        // Simultaneous I read and D write: D first, I two cycles after D resp
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h100;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h200;
        d_pmem_wdata   = {16{16'h1234}};
        step();
        check("sim_d_write", LINE_W'({pmem_read, pmem_write}), LINE_W'(2'b01));
        check("sim_d_addr", LINE_W'(pmem_address), LINE_W'(32'h200));
        check("sim_d_wdata", pmem_wdata, {16{16'h1234}});
        check("sim_streak", LINE_W'(dut.d_streak_q), LINE_W'(1));
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h33334444}};
        push_resp(OWN_D, {8{32'h33334444}});
        step();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        check("sim_gap", LINE_W'({pmem_read, pmem_write}), '0);
        step();
        check("sim_i_read", LINE_W'({pmem_read, pmem_write}), LINE_W'(2'b10));
        check("sim_i_addr", LINE_W'(pmem_address), LINE_W'(32'h100));
        check("sim_streak_clear", LINE_W'(dut.d_streak_q), '0);
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h55556666}};
        push_resp(OWN_I, {8{32'h55556666}});
        step();
        pmem_resp = 1'b0;
        clear_reqs();
        step();

        // Starvation: I held at 0x40 while D issues three back-to-back reads
        d_addrs[0] = 32'h400;
        d_addrs[1] = 32'h420;
        d_addrs[2] = 32'h440;
        di       = 0;
        streak_m = 0;
        i_pend   = 1'b1;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h40;
        d_pmem_read    = 1'b1;
        d_pmem_address = d_addrs[0];
        for (int t = 0; t < 4; t++) begin
            d_pend = (di < 3);
            exp_d  = d_pend && (!i_pend || streak_m != 2);
            if (exp_d) begin
                if (i_pend && streak_m < 2) streak_m++;
            end else begin
                streak_m = 0;
            end
            step();
            check("starve_op", LINE_W'({pmem_read, pmem_write}), LINE_W'(2'b10));
            check("starve_addr", LINE_W'(pmem_address),
                  LINE_W'(exp_d ? d_addrs[di] : 32'h40));
            check("starve_streak", LINE_W'(dut.d_streak_q), LINE_W'(streak_m));
            step();
            rd         = {8{32'hF0F00000 + 32'(t)}};
            pmem_resp  = 1'b1;
            pmem_rdata = rd;
            push_resp(exp_d ? OWN_D : OWN_I, rd);
            step();
            pmem_resp = 1'b0;
            if (exp_d) begin
                di++;
                if (di < 3) d_pmem_address = d_addrs[di];
                else d_pmem_read = 1'b0;
            end else begin
                i_pmem_read = 1'b0;
                i_pend      = 1'b0;
            end
        end
        step();

        // Spurious resp in IDLE
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h99999999}};
        #1;
        check("spur_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
        step();
        check("spur_state", LINE_W'(dut.state_q), LINE_W'(IDLE));
        check("spur_req", LINE_W'({pmem_read, pmem_write}), '0);
        pmem_resp = 1'b0;
        step();

        // Reset two cycles into D_BUSY
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h500;
        d_pmem_wdata   = {8{32'h5555AAAA}};
        step();
        check("rstmid_granted", LINE_W'(pmem_write), LINE_W'(1));
        step();
        step();
        rst = 1'b0;
        #1;
        check("rstmid_write", LINE_W'(pmem_write), '0);
        check("rstmid_read", LINE_W'(pmem_read), '0);
        check("rstmid_addr", LINE_W'(pmem_address), '0);
        check("rstmid_wdata", pmem_wdata, '0);
        clear_reqs();
        step();
        rst        = 1'b1;
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h77778888}};
        #1;
        check("rstmid_stale_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
        check("rstmid_state", LINE_W'(dut.state_q), LINE_W'(IDLE));
        step();
        pmem_resp = 1'b0;
        check("rstmid_state_after", LINE_W'(dut.state_q), LINE_W'(IDLE));
        step();

        check("scoreboard_drained", LINE_W'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
